rr_grant_arbiter: RTL

- Round-robin arbiter that shares one resource (e.g. the frame-buffer/SDRAM write port) between PORTS requesters.
- Grants are registered and one-hot. The holder keeps the grant until it drops its request or the resource signals done.
- Priority selection uses a masked "lowest set bit" search over a rotating pointer, implemented with an iterative loop (no recursive instantiation; the synthesis tool does not support it).

---
 rtl/rr_grant_arbiter_if.sv | 24 ++
 rtl/rr_grant_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side drives requests and done; the slave side (the arbiter) returns the grant.
interface rr_grant_arbiter_if #(
    parameter int unsigned PORTS = 4
);
    localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0] req;
    logic             done;
    logic [PORTS-1:0] grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_valid, grant_idx, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, grant_idx, timeout
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with registered one-hot grant and a one-cycle turnaround gap.
// Define ARB_TIMEOUT_EN to add a hold counter that forces release after TIMEOUT cycles.
module rr_grant_arbiter #(
    parameter int unsigned PORTS   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int unsigned      IDX_W    = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(PORTS - 1);

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t           state_q, state_d;
    logic [PORTS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic [PORTS-1:0] sel_oh;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             holder_release;
    logic             force_release;

    // Two passes: first the lowest requester strictly above the pointer, then wrap to the lowest overall.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sel_oh    = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (!sel_found && bus.req[i] && (i > int'(last_q))) begin
                sel_found  = 1'b1;
                sel_idx    = IDX_W'(i);
                sel_oh[i]  = 1'b1;
            end
        end
        for (int i = 0; i < int'(PORTS); i++) begin
            if (!sel_found && bus.req[i]) begin
                sel_found  = 1'b1;
                sel_idx    = IDX_W'(i);
                sel_oh[i]  = 1'b1;
            end
        end
    end

    assign holder_release = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] hold_cnt_q;

    // Counter is zero in the first OWN cycle, so the grant is visible for exactly TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (state_q != OWN) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
        end
    end

    assign force_release = (state_q == OWN) && (hold_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign force_release      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE, GAP: begin
                if (sel_found) begin
                    state_d = OWN;
                    grant_d = sel_oh;
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    last_d  = sel_idx;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                // A normal release in the same cycle as the limit wins, so timeout stays low.
                if (holder_release || force_release) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    timeout_d = ~holder_release;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= LAST_RST;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_idx   = idx_q;
    assign bus.timeout     = timeout_q;
endmodule
